deconcat_stream: RTL and testbench

DECONCAT_STREAM -- requirements
Module: deconcat_stream

---
 rtl/deconcat_pkg.sv | 19 +
 rtl/deconcat_stream_if.sv | 45 ++++
 rtl/deconcat_slice_sel.sv | 31 +++
 rtl/deconcat_stream.sv | 100 ++++++++++
 tb/tb_deconcat_stream.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/deconcat_pkg.sv
// Shared definitions for the deconcat_stream slice: FSM state encoding,
// default geometry and a helper for the slice-counter width.
package deconcat_pkg;

    // IDLE waits for a word; EMIT presents the buffered word one slice at a time.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int OUT_W_DEF = 4;
    localparam int RATIO_DEF = 2;

    // Bits needed to count 0..ratio-1; never narrower than one bit.
    function automatic int cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/deconcat_stream_if.sv
// Stream bundle for deconcat_stream: one wide input word channel and one
// narrow output slice channel.
//
// Handshake: on either channel a transfer happens in a cycle exactly when
// valid and ready are both high; a source holds valid and its payload
// steady until that transfer, and a sink may raise or lower ready freely.
interface deconcat_stream_if
    import deconcat_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int RATIO = RATIO_DEF
);
    localparam int IN_W = OUT_W * RATIO;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    // DUT side: consumes words, produces slices.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    // Environment side: produces words, consumes slices.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/deconcat_slice_sel.sv
// Pure slice multiplexer: picks slice number i_idx (in emission order) out
// of the buffered word. Emission order is the only build-time option:
// DECONCAT_STREAM_LSB_FIRST_EN defined -> least-significant slice first,
// otherwise most-significant slice first.
module deconcat_slice_sel
    import deconcat_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int RATIO = RATIO_DEF,
    parameter int CNT_W = cnt_w(RATIO)
) (
    input  logic [OUT_W*RATIO-1:0] i_buf,
    input  logic [CNT_W-1:0]       i_idx,
    output logic [OUT_W-1:0]       o_slice
);

    // Map the emission index onto a bit position in the buffered word.
    always_comb begin
        o_slice = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (i_idx == CNT_W'(k)) begin
`ifdef DECONCAT_STREAM_LSB_FIRST_EN
                o_slice = i_buf[k*OUT_W +: OUT_W];
`else
                o_slice = i_buf[(RATIO-1-k)*OUT_W +: OUT_W];
`endif
            end
        end
    end

endmodule

// File: rtl/deconcat_stream.sv
// deconcat_stream: splits each OUT_W*RATIO-bit input word into RATIO
// OUT_W-bit slices. A new word can be accepted on the cycle its last slice
// leaves, so back-to-back words stream with no bubbles.
// Optional build macro: DECONCAT_STREAM_LSB_FIRST_EN (LSB slice first).
module deconcat_stream
    import deconcat_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int RATIO = RATIO_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    deconcat_stream_if.slave   bus,
    output state_t             o_state
);

    localparam int IN_W  = OUT_W * RATIO;
    localparam int CNT_W = cnt_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IN_W-1:0]    r_buf;
    logic [IN_W-1:0]    w_buf_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_emit;
    logic               w_last;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [OUT_W-1:0]   w_slice;

    deconcat_slice_sel #(
        .OUT_W (OUT_W),
        .RATIO (RATIO),
        .CNT_W (CNT_W)
    ) u_slice_sel (
        .i_buf   (r_buf),
        .i_idx   (r_cnt),
        .o_slice (w_slice)
    );

    // State, word buffer and slice counter; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Handshake outputs and next-state: accept a word when idle or when the
    // last slice is leaving this cycle; otherwise step through the slices.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;

        w_emit = (r_state == EMIT);
        w_last = w_emit && (r_cnt == LAST_IDX);

        bus.in_ready  = !w_emit || (w_last && bus.out_ready);
        bus.out_valid = w_emit;
        bus.out_data  = w_emit ? w_slice : '0;
        bus.out_last  = w_last;

        w_in_fire  = bus.in_valid && bus.in_ready;
        w_out_fire = w_emit && bus.out_ready;

        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_buf_nxt   = bus.in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_out_fire) begin
                    if (!w_last) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else if (w_in_fire) begin
                        w_buf_nxt = bus.in_data;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_deconcat_stream.sv
// Self-checking bench for deconcat_stream: directed scenarios on the default
// geometry (4-bit slices, ratio 2), a randomized run against a queue-based
// reference model, and a directed word on a 2-bit x 4 instance.
module tb_deconcat_stream;
    import deconcat_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    deconcat_stream_if #(.OUT_W(4), .RATIO(2)) bus  ();
    deconcat_stream_if #(.OUT_W(2), .RATIO(4)) bus2 ();

    state_t st1;
    state_t st2;

    deconcat_stream #(.OUT_W(4), .RATIO(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (st1)
    );

    deconcat_stream #(.OUT_W(2), .RATIO(4)) dut_p (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus2),
        .o_state (st2)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];   // {last, slice} expected on the default instance
    logic       r_iv;
    logic       r_ordy;
    logic [7:0] r_word;
    logic       exp_rdy;
    logic [1:0] p_exp[4];

    // Expected slice number i of an 8-bit word, in emission order.
    function automatic logic [3:0] nib(input logic [7:0] w, input int i);
`ifdef DECONCAT_STREAM_LSB_FIRST_EN
        return 4'((w >> (4 * i)) & 8'h0F);
`else
        return 4'((w >> (4 * (1 - i))) & 8'h0F);
`endif
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive the default instance for one cycle, then settle before checking.
    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic drive2(input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        bus2.in_valid  = iv;
        bus2.in_data   = d;
        bus2.out_ready = ordy;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic l);
        chk1({tag, "_valid"}, bus.out_valid, v);
        chk4({tag, "_data"},  bus.out_data,  d);
        chk1({tag, "_last"},  bus.out_last,  l);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = 8'h00;
        bus2.out_ready = 1'b0;

        // Reset state, including an offered word that must not be taken.
        drive(1'b1, 8'hFF, 1'b1);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk_out("rst", 1'b0, 4'h0, 1'b0);
        drive(1'b1, 8'hFF, 1'b1);
        chk1("rst_state", st1, IDLE);
        chk_out("rst_hold", 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Single word.
        drive(1'b1, 8'h6A, 1'b1);
        chk1("w1_in_ready", bus.in_ready, 1'b1);
        chk1("w1_pre_valid", bus.out_valid, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("w1_s0", 1'b1, nib(8'h6A, 0), 1'b0);
        chk1("w1_s0_in_ready", bus.in_ready, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("w1_s1", 1'b1, nib(8'h6A, 1), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("w1_idle", 1'b0, 4'h0, 1'b0);
        chk1("w1_idle_state", st1, IDLE);

        // Back-to-back words with the second held valid throughout.
        drive(1'b1, 8'h6A, 1'b1);
        drive(1'b1, 8'hC3, 1'b1);
        chk_out("b2b_s0", 1'b1, nib(8'h6A, 0), 1'b0);
        chk1("b2b_s0_in_ready", bus.in_ready, 1'b0);
        drive(1'b1, 8'hC3, 1'b1);
        chk_out("b2b_s1", 1'b1, nib(8'h6A, 1), 1'b1);
        chk1("b2b_s1_in_ready", bus.in_ready, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("b2b_s2", 1'b1, nib(8'hC3, 0), 1'b0);
        chk1("b2b_s2_in_ready", bus.in_ready, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("b2b_s3", 1'b1, nib(8'hC3, 1), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("b2b_idle", 1'b0, 4'h0, 1'b0);

        // Backpressure: slices hold, offered words are refused.
        drive(1'b1, 8'h5F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hEE, 1'b0);
            chk_out("bp_hold", 1'b1, nib(8'h5F, 0), 1'b0);
            chk1("bp_in_ready", bus.in_ready, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b1);
        chk_out("bp_s0", 1'b1, nib(8'h5F, 0), 1'b0);
        drive(1'b1, 8'hEE, 1'b0);
        chk_out("bp_last_hold", 1'b1, nib(8'h5F, 1), 1'b1);
        chk1("bp_last_in_ready", bus.in_ready, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("bp_s1", 1'b1, nib(8'h5F, 1), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("bp_idle", 1'b0, 4'h0, 1'b0);

        // Reset in the middle of a word.
        drive(1'b1, 8'h6A, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        chk_out("mid_s0", 1'b1, nib(8'h6A, 0), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 4'h0, 1'b0);
        chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
        chk1("mid_rst_state", st1, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h12, 1'b1);
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);
        chk1("post_rst_valid", bus.out_valid, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("post_rst_s0", 1'b1, nib(8'h12, 0), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("post_rst_s1", 1'b1, nib(8'h12, 1), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("post_rst_idle", 1'b0, 4'h0, 1'b0);

`ifdef DECONCAT_STREAM_LSB_FIRST_EN
        // LSB-first order with literal expectations.
        drive(1'b1, 8'h6A, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("lsb_s0", 1'b1, 4'hA, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("lsb_s1", 1'b1, 4'h6, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk_out("lsb_idle", 1'b0, 4'h0, 1'b0);
`endif

        // Randomized traffic against a queue of pending slices: a word is
        // taken when nothing is pending, or when only its predecessor's last
        // slice is pending and leaves this cycle.
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            r_iv   = ($urandom_range(0, 3) != 0);
            r_ordy = ($urandom_range(0, 3) != 0);
            r_word = 8'($urandom_range(0, 255));
            drive(r_iv, r_word, r_ordy);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && r_ordy);
            chk1("rnd_in_ready", bus.in_ready, exp_rdy);
            chk1("rnd_out_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk4("rnd_out_data", bus.out_data, exp_q[0][3:0]);
                chk1("rnd_out_last", bus.out_last, exp_q[0][4]);
                if (r_ordy) void'(exp_q.pop_front());
            end
            if (r_iv && exp_rdy) begin
                for (int i = 0; i < 2; i++) begin
                    exp_q.push_back({(i == 1), nib(r_word, i)});
                end
            end
        end

        // 2-bit slices, ratio 4.
`ifdef DECONCAT_STREAM_LSB_FIRST_EN
        p_exp = '{2'd0, 2'd1, 2'd3, 2'd2};
`else
        p_exp = '{2'd2, 2'd3, 2'd1, 2'd0};
`endif
        drive2(1'b1, 8'hB4, 1'b1);
        chk1("p_in_ready", bus2.in_ready, 1'b1);
        chk1("p_pre_valid", bus2.out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive2(1'b0, 8'h00, 1'b1);
            chk1("p_valid", bus2.out_valid, 1'b1);
            chk4("p_data", 4'(bus2.out_data), 4'(p_exp[i]));
            chk1("p_last", bus2.out_last, (i == 3));
        end
        drive2(1'b0, 8'h00, 1'b1);
        chk1("p_idle_valid", bus2.out_valid, 1'b0);
        chk1("p_idle_state", st2, IDLE);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
